// File: rtl/lsu_axi_master.sv
// ---------------------------------------------------------------------------
// lsu_axi_master
// Bridges the core load/store stage to an AXI-lite data-memory slave.
// One request at a time is accepted on a valid/ready handshake, turned into a
// word-aligned AXI-lite read or write, and completed with a single-cycle
// response pulse carrying extended load data and an error flag.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            core request handshake (ready = bridge idle)
//   req_we, req_size, req_addr,
//   req_wdata                      store flag, RISC-V funct3 size, byte address,
//                                  right-aligned store data
//   resp_valid, resp_rdata,
//   resp_err                       one-cycle completion pulse, load data, error
//   ar*/r*/aw*/w*/b*               AXI-lite master channels, all outputs registered
//
// Parameter
//   TIMEOUT   cycles allowed per slave handshake before giving up; 0 = never
// ---------------------------------------------------------------------------
module lsu_axi_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [7:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // The timer only ever needs to reach TIMEOUT-1.
  localparam int unsigned TW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 32'd1) ? TW'(TIMEOUT - 32'd1) : '0;

  state_t      state_r;
  logic [2:0]  size_r;
  logic [1:0]  off_r;
  logic [TW-1:0] timer_r;
  logic        req_ready_r;
  logic        arvalid_r;
  logic [31:0] araddr_r;
  logic        rready_r;
  logic        awvalid_r;
  logic [31:0] awaddr_r;
  logic        wvalid_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        bready_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        timeout_s;

  // Misaligned halfword/word or an unsupported funct3 encoding.
  function automatic logic access_fault(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      3'b010:         return (off != 2'b00);
      default:        return 1'b1;
    endcase
  endfunction

  // Byte-lane strobes for a store of the given size at the given offset.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'b000, 3'b100: return 4'b0001 << off;
      3'b001, 3'b101: return 4'b0011 << off;
      default:        return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so the strobe picks the right copy.
  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] d);
    case (size)
      3'b000, 3'b100: return {4{d[7:0]}};
      3'b001, 3'b101: return {2{d[15:0]}};
      default:        return d;
    endcase
  endfunction

  // Shift the addressed lane down and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign timeout_s = (TIMEOUT != 32'd0) && (timer_r >= TLIM);

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign arvalid    = arvalid_r;
  assign araddr     = araddr_r;
  assign rready     = rready_r;
  assign awvalid    = awvalid_r;
  assign awaddr     = awaddr_r;
  assign wvalid     = wvalid_r;
  assign wdata      = wdata_r;
  assign wstrb      = {4'b0000, wstrb_r};
  assign bready     = bready_r;

  // Request/transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      size_r       <= 3'b000;
      off_r        <= 2'b00;
      timer_r      <= '0;
      req_ready_r  <= 1'b0;
      arvalid_r    <= 1'b0;
      araddr_r     <= 32'h0000_0000;
      rready_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      awaddr_r     <= 32'h0000_0000;
      wvalid_r     <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'b0000;
      bready_r     <= 1'b0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      // Counts wait cycles; every state change below clears it.
      timer_r <= timer_r + 1'b1;
      case (state_r)
        ST_IDLE: begin
          timer_r <= '0;
          if (req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            size_r      <= req_size;
            off_r       <= req_addr[1:0];
            if (access_fault(req_size, req_addr[1:0])) begin
              // Rejected without touching the bus.
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              state_r      <= ST_RESP;
            end else if (req_we) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              awaddr_r  <= {req_addr[31:2], 2'b00};
              wdata_r   <= lane_data(req_size, req_wdata);
              wstrb_r   <= lane_strobe(req_size, req_addr[1:0]);
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= ST_W;
            end else begin
              arvalid_r <= 1'b1;
              araddr_r  <= {req_addr[31:2], 2'b00};
              state_r   <= ST_AR;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            timer_r   <= '0;
            state_r   <= ST_R;
          end else if (timeout_s) begin
            arvalid_r    <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_AR;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= (rresp != 2'b00);
            resp_rdata_r <= (rresp != 2'b00) ? 32'h0000_0000 : load_extend(size_r, off_r, rdata);
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else if (timeout_s) begin
            rready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_R;
          end
        end
        ST_W: begin
          // Address and data channels complete independently.
          if (awvalid_r && awready) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (wvalid_r && wready) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_done_r && w_done_r) begin
            bready_r <= 1'b1;
            timer_r  <= '0;
            state_r  <= ST_B;
          end else if (timeout_s) begin
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_W;
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= (bresp != 2'b00);
            resp_rdata_r <= 32'h0000_0000;
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else if (timeout_s) begin
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
            timer_r      <= '0;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_B;
          end
        end
        ST_RESP: begin
          // The pulse lasts exactly this one cycle.
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          req_ready_r  <= 1'b1;
          timer_r      <= '0;
          state_r      <= ST_IDLE;
        end
        default: begin
          arvalid_r    <= 1'b0;
          rready_r     <= 1'b0;
          awvalid_r    <= 1'b0;
          wvalid_r     <= 1'b0;
          bready_r     <= 1'b0;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b0;
          timer_r      <= '0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_axi_master
// Randomized bench for lsu_axi_master. A request driver predicts each
// response from the access rules and a word memory, pushing it into a
// scoreboard queue; a monitor pops and compares on every resp_valid. A
// behavioural AXI-lite slave with random per-channel delays serves the bus
// from the same memory and checks addresses, write lanes and valid drops.
// ---------------------------------------------------------------------------
module tb_lsu_axi_master;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  lsu_axi_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_resp_c = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [7:0] strb; } wr_t;
  resp_t       exp_q[$];
  logic [31:0] rd_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem [16];

  // slave knobs: fixed delay when >= 0, else random 0..max_dly
  int max_dly = 0;
  int ar_fix = -1, r_fix = -1, aw_fix = -1, w_fix = -1, b_fix = -1;
  bit stall = 1'b0;

  // cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic int dly(input int fix);
    if (fix >= 0) return fix;
    return $urandom_range(0, max_dly);
  endfunction

  // Predict and issue one request; returns the cycle count at acceptance.
  task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_lit, input logic [31:0] lit_rdata,
                       input logic lit_err, output int acc_c);
    int n, off, k;
    bit bad, buserr, acc;
    longint unsigned v, m;
    resp_t r;
    wr_t w;
    n = nbytes(size);
    off = int'(addr % 4);
    bad = (n == 0) || ((addr % n) != 0);
    buserr = (addr[31:28] == 4'hF);
    r.err = bad || buserr;
    r.rdata = 32'h0;
    if (!bad && !we) begin
      rd_q.push_back({addr[31:2], 2'b00});
      if (!buserr) begin
        m = (64'd1 << (8 * n)) - 64'd1;
        v = (64'(mem[addr[5:2]]) >> (8 * off)) & m;
        if ((size == 3'd0 || size == 3'd1) && v > (m >> 1)) v = v - m - 64'd1;
        r.rdata = v[31:0];
      end
    end
    if (!bad && we) begin
      w.addr = {addr[31:2], 2'b00};
      w.strb = 8'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) w.data[8*i +: 8] = wd[8*(i % n) +: 8];
      wr_q.push_back(w);
    end
    if (use_lit) begin
      r.rdata = lit_rdata;
      r.err = lit_err;
    end
    exp_q.push_back(r);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
    acc = 1'b0; k = 0; acc_c = 0;
    while (!acc && k < 200) begin
      acc = req_ready;
      acc_c = cyc;
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept: req_ready never seen, required 1 within 200 cycles");
    end
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (resp_valid) begin
        last_resp_c = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h, required none", resp_rdata);
        end else begin
          r = exp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        end
      end
    end
  end

  // Behavioural AXI-lite slave, acting on the falling edge.
  initial begin
    bit rd_pend, aw_got, w_got, b_pend, aw_hs, w_hs;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] rd_a, wr_a, wr_d, p_araddr, p_awaddr, p_wdata;
    logic [7:0] wr_s, p_wstrb;
    logic p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
    wr_t w;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; wr_s = 0;
    p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
        rd_q.delete(); wr_q.delete();
      end else begin
        // handshakes that completed on the last rising edge
        if (arready && p_arvalid) begin
          arready = 0;
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ar: got araddr=0x%08h, required no read", p_araddr);
          end else begin
            check("araddr", p_araddr, rd_q.pop_front());
          end
          rd_pend = 1; rd_a = p_araddr; r_cnt = dly(r_fix);
        end
        if (rvalid && p_rready) rvalid = 0;
        aw_hs = awready && p_awvalid;
        w_hs = wready && p_wvalid;
        if (aw_hs) begin
          awready = 0; aw_got = 1; wr_a = p_awaddr;
          check("awvalid_drop", {31'h0, awvalid}, 32'h0);
          if (!w_got && !w_hs) check("wvalid_held", {31'h0, wvalid}, 32'h1);
        end
        if (w_hs) begin
          wready = 0; w_got = 1; wr_d = p_wdata; wr_s = p_wstrb;
          check("wvalid_drop", {31'h0, wvalid}, 32'h0);
          if (!aw_got) check("awvalid_held", {31'h0, awvalid}, 32'h1);
        end
        if (bvalid && p_bready) bvalid = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got awaddr=0x%08h, required no write", wr_a);
          end else begin
            w = wr_q.pop_front();
            check("awaddr", wr_a, w.addr);
            check("wdata", wr_d, w.data);
            check("wstrb", {24'h0, wr_s}, {24'h0, w.strb});
          end
          b_pend = 1; b_cnt = dly(b_fix);
        end
        // new drives
        if (arvalid && !arready && !stall) begin
          if (ar_cnt == 0) arready = 1; else ar_cnt--;
        end else if (!arvalid) ar_cnt = dly(ar_fix);
        if (awvalid && !awready && !aw_got) begin
          if (aw_cnt == 0) awready = 1; else aw_cnt--;
        end else if (!awvalid) aw_cnt = dly(aw_fix);
        if (wvalid && !wready && !w_got) begin
          if (w_cnt == 0) wready = 1; else w_cnt--;
        end else if (!wvalid) w_cnt = dly(w_fix);
        if (rd_pend && !rvalid) begin
          if (r_cnt == 0) begin
            rvalid = 1; rdata = mem[rd_a[5:2]];
            rresp = (rd_a[31:28] == 4'hF) ? 2'b10 : 2'b00;
            rd_pend = 0;
          end else r_cnt--;
        end
        if (b_pend && !bvalid) begin
          if (b_cnt == 0) begin
            bvalid = 1; bresp = (wr_a[31:28] == 4'hF) ? 2'b10 : 2'b00;
            b_pend = 0;
          end else b_cnt--;
        end
        p_arvalid = arvalid; p_araddr = araddr; p_rready = rready;
        p_awvalid = awvalid; p_awaddr = awaddr; p_wvalid = wvalid;
        p_wdata = wdata; p_wstrb = wstrb; p_bready = bready;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Main sequence.
  initial begin
    int a, k;
    logic [2:0] sz_tbl [10];
    sz_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'h12F4_5678;

    // reset values
    repeat (3) @(negedge clk);
    check("reset_ctrl", {24'h0, req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 32'h0);
    check("reset_addr", araddr | awaddr | wdata | resp_rdata, 32'h0);
    check("reset_wstrb", {24'h0, wstrb}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", {31'h0, req_ready}, 32'h1);

    // zero-wait directed cases
    issue(1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, a);
    drain(50); check("lat_store", 32'(last_resp_c - a), 32'd4);
    issue(1'b1, 3'd0, 32'h8000_0013, 32'h0000_00A5, 1'b1, 32'h0, 1'b0, a);
    drain(50);
    issue(1'b0, 3'd0, 32'h8000_0012, 32'h0, 1'b1, 32'hFFFF_FFF4, 1'b0, a);
    drain(50); check("lat_load", 32'(last_resp_c - a), 32'd3);
    issue(1'b0, 3'd4, 32'h8000_0012, 32'h0, 1'b1, 32'h0000_00F4, 1'b0, a);
    issue(1'b0, 3'd1, 32'h8000_0012, 32'h0, 1'b1, 32'h0000_12F4, 1'b0, a);
    drain(50);
    issue(1'b0, 3'd2, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 1'b1, a);
    drain(50); check("lat_misaligned", 32'(last_resp_c - a), 32'd1);
    issue(1'b0, 3'd2, 32'hF000_0004, 32'h0, 1'b1, 32'h0, 1'b1, a);
    issue(1'b1, 3'd1, 32'hF000_0006, 32'h1234_5678, 1'b1, 32'h0, 1'b1, a);
    drain(50);

    // wready well ahead of awready
    w_fix = 0; aw_fix = 3;
    issue(1'b1, 3'd2, 32'h8000_0020, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, a);
    drain(50);
    w_fix = 3; aw_fix = 0;
    issue(1'b1, 3'd1, 32'h8000_0022, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0, a);
    drain(50);
    w_fix = -1; aw_fix = -1;

    // slave never answers the read address: timeout
    stall = 1'b1;
    issue(1'b0, 3'd2, 32'h8000_0024, 32'h0, 1'b1, 32'h0, 1'b1, a);
    drain(300);
    check("timeout_arvalid", {31'h0, arvalid}, 32'h0);
    stall = 1'b0;
    rd_q.delete();

    // reset while waiting for read data
    r_fix = 10;
    issue(1'b0, 3'd2, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 1'b0, a);
    k = 0;
    while (!rready && k < 50) begin @(negedge clk); k++; end
    check("rready_before_rst", {31'h0, rready}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {29'h0, rready, resp_valid, req_ready}, 32'h0);
    @(negedge clk);
    check("rst_mid_idle", {31'h0, req_ready}, 32'h1);
    repeat (15) @(negedge clk);
    r_fix = -1;

    // randomized traffic with random slave delays
    max_dly = 3;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] base;
      base = ($urandom_range(0, 9) == 0) ? 32'hF000_0000 : 32'h8000_0000;
      issue(1'($urandom_range(0, 1)), sz_tbl[$urandom_range(0, 9)],
            base | 32'($urandom_range(0, 63)), $urandom, 1'b0, 32'h0, 1'b0, a);
    end
    drain(200);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
